pll_rst_seq: RTL and testbench
==============================

// Module: pll_rst_seq
// PURPOSE
//  Control-side counterpart of the Gowin rPLL wrapper: drives the rPLL RESET input and reads its LOCK output.
//  Runs on the 50 MHz board clock. It pulses the PLL reset, waits for lock with a timeout and limited retries,
//  then debounces lock. Only then does it release the synchronous reset of the sigma-delta datapath.
//  If lock is lost while running, the datapath goes back into reset and the PLL is re-initialised.
// PARAMETERS
//  PLL_RST_CYCLES      16     pll_reset pulse width in clkin cycles (>=3)
//  LOCK_TIMEOUT_CYCLES 65536  cycles to wait in WAIT_LOCK before a retry
//  LOCK_STABLE_CYCLES  1024   consecutive synchronised lock-high cycles required before RUN
//  MAX_RETRIES         3      PLL reset retries after the first attempt before FAULT
//  CNT_W               17     width of the shared cycle counter; must hold the largest of the cycle counts
// PORTS
//  clkin      in   1      50 MHz board clock; the only clock
//  reset      in   1      synchronous, active-high reset
//  lock       in   1      rPLL LOCK, asynchronous to clkin
//  pll_reset  out  1      to rPLL RESET; high = PLL held in reset
//  sys_reset  out  1      synchronous active-high reset for the downstream datapath
//  ready      out  1      high only in RUN
//  fault      out  1      high only in FAULT (sticky)
//  retry_cnt  out  2      retries used in the current attempt sequence
//  loss_cnt   out  8      count of lock losses in RUN
// BEHAVIOUR
//  Reset values: pll_reset=1, sys_reset=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0, lock sync flops=0, state=PLL_RST, counter=0.
//  All outputs are registered. reset has priority over every state and takes effect at the next edge, including mid-sequence.
//  lock passes through a 2-flop synchroniser (lock_s). lock_s lags lock by 2 edges.
//  PLL_RST:   pll_reset=1, sys_reset=1. Leave after exactly PLL_RST_CYCLES cycles, then clear the counter and go to WAIT_LOCK.
//  WAIT_LOCK: pll_reset=0, sys_reset=1.
//    - lock_s=1: go to STABLE with the counter set to 1.
//    - Counter reaches LOCK_TIMEOUT_CYCLES-1 and retry_cnt<MAX_RETRIES: retry_cnt+1, go to PLL_RST.
//    - Counter reaches LOCK_TIMEOUT_CYCLES-1 and retry_cnt==MAX_RETRIES: go to FAULT.
//  STABLE:    pll_reset=0, sys_reset=1.
//    - lock_s=0: go to WAIT_LOCK with the counter cleared (full timeout restarts).
//    - LOCK_STABLE_CYCLES consecutive lock_s=1 samples: go to RUN.
//  RUN:       sys_reset=0 and ready=1, both changing on the same edge that enters RUN.
//    - lock_s=0: on the next edge sys_reset=1, ready=0, loss_cnt+1, retry_cnt=0, go to PLL_RST.
//  FAULT:     pll_reset=1, sys_reset=1, fault=1, ready=0. Exit only via reset.
//  Counter does not wrap: it clears on every state change and saturates at its compare value.
//  retry_cnt saturates at MAX_RETRIES.
//  sys_reset and ready are exact complements in every state.
//  Timing: with lock held high before reset drops, ready rises exactly PLL_RST_CYCLES+LOCK_STABLE_CYCLES+1 edges
//  after the first edge with reset=0.
// CONFIGURATION
//  PLL_RST_SEQ_LOSS_CNT_EN defined:
//    - loss_cnt counts lock losses in RUN.
//    - loss_cnt saturates at 8'hFF and clears only on reset.
//  PLL_RST_SEQ_LOSS_CNT_EN not defined:
//    - No counter logic is built.
//    - loss_cnt is tied to 8'h00.
//  All other behaviour is identical.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=6)
//  1. lock=1 throughout, reset released
//     -> pll_reset high 4 cycles; ready/sys_reset toggle on edge 13; retry_cnt=0.
//  2. lock=0 forever
//     -> three 4-cycle pll_reset pulses at 36-cycle spacing; retry_cnt steps 1 then 2; fault=1 after third timeout;
//        outputs frozen until reset.
//  3. lock rises 20 cycles into WAIT_LOCK, with a 1-cycle low glitch 5 cycles into STABLE
//     -> WAIT_LOCK is re-entered with the timeout restarted; ready rises 8 cycles after the final stable lock_s=1.
//  4. In RUN, drop lock for 1 cycle
//     -> sys_reset=1 and ready=0 3 edges later; pll_reset pulses 4 cycles; loss_cnt=1 (0 if macro undefined);
//        RUN is re-reached when lock is high.
//  5. Assert reset for 1 cycle in the middle of STABLE and again in FAULT
//     -> all outputs at reset values on the next edge; sequence restarts from PLL_RST.
//  6. With the macro defined, produce 300 lock losses in RUN
//     -> loss_cnt holds at 8'hFF.

Source files
------------

// File: rtl/pll_rst_seq.sv
// PLL reset / lock sequencer: pulses the rPLL reset, waits for a debounced lock, then releases the datapath reset.
// Optional lock-loss counter enabled by defining PLL_RST_SEQ_LOSS_CNT_EN.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 17
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;
    logic             lock_m;
    logic             lock_s;

    // The sample taken in WAIT_LOCK counts towards stability, so STABLE starts at 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = CNT_W'(1);
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = PLL_RST;
                    end else begin
                        state_nxt = FAULT;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    retry_nxt = 2'd0;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state     <= PLL_RST;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            lock_m    <= lock;
            lock_s    <= lock_m;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_reset <= (state_nxt == PLL_RST) || (state_nxt == FAULT);
            sys_reset <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            fault     <= (state_nxt == FAULT);
        end
    end

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    logic lost;

    assign lost = (state == RUN) && !lock_s;

    always_ff @(posedge clkin) begin
        if (reset) begin
            loss_cnt <= 8'h00;
        end else if (lost && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`else
    assign loss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq using small cycle counts; loss_cnt expectations follow PLL_RST_SEQ_LOSS_CNT_EN.
module tb_pll_rst_seq;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       lock  = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
    localparam logic [7:0] LOSS1 = 8'd1;
`else
    localparam logic [7:0] LOSS1 = 8'd0;
`endif

    typedef struct {
        bit          restart;
        logic        lock_lvl;
        int          edge_at;
        string       name;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    pll_rst_seq #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2),
        .CNT_W              (6)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .lock     (lock),
        .pll_reset(pll_reset),
        .sys_reset(sys_reset),
        .ready    (ready),
        .fault    (fault),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic logic [13:0] mk(input logic p, input logic s, input logic r, input logic f,
                                       input logic [1:0] rc, input logic [7:0] lc);
        return {p, s, r, f, rc, lc};
    endfunction

    task automatic apply_stimulus(input logic rst, input logic lk, input int n);
        for (int i = 0; i < n; i++) begin
            reset = rst;
            lock  = lk;
            @(posedge clkin);
            #1;
            edge_n++;
        end
    endtask

    task automatic check_output(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = {pll_reset, sys_reset, ready, fault, retry_cnt, loss_cnt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got p/s/r/f/retry/loss=%b required=%b", name, edge_n, got, exp);
        end
    endtask

    task automatic reset_dut(input logic lk);
        apply_stimulus(1'b1, lk, 1);
        check_output("reset_values", mk(1, 1, 0, 0, 2'd0, 8'd0));
        edge_n = 0;
    endtask

    task automatic run_to(input int target, input logic lk);
        while (edge_n < target) apply_stimulus(1'b0, lk, 1);
    endtask

    task automatic add_vec(input bit r, input logic l, input int e, input string n, input logic [13:0] x);
        vec_t v;
        v.restart  = r;
        v.lock_lvl = l;
        v.edge_at  = e;
        v.name     = n;
        v.exp      = x;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input logic want, input int bound, input string name);
        int n;
        n = 0;
        while (ready !== want && n < bound) begin
            apply_stimulus(1'b0, 1'b1, 1);
            n++;
        end
        if (ready !== want) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: ready=%b required=%b", name, ready, want);
        end
    endtask

    initial begin
        // Lock held high from reset, then lock never arriving.
        add_vec(1, 1'b1,   3, "s1_pll_hold",    mk(1, 1, 0, 0, 2'd0, 8'd0));
        add_vec(0, 1'b1,   4, "s1_pll_release", mk(0, 1, 0, 0, 2'd0, 8'd0));
        add_vec(0, 1'b1,  12, "s1_not_ready",   mk(0, 1, 0, 0, 2'd0, 8'd0));
        add_vec(0, 1'b1,  13, "s1_ready",       mk(0, 0, 1, 0, 2'd0, 8'd0));
        add_vec(0, 1'b1,  20, "s1_run_hold",    mk(0, 0, 1, 0, 2'd0, 8'd0));
        add_vec(1, 1'b0,   4, "s2_wait",        mk(0, 1, 0, 0, 2'd0, 8'd0));
        add_vec(0, 1'b0,  35, "s2_pre_retry1",  mk(0, 1, 0, 0, 2'd0, 8'd0));
        add_vec(0, 1'b0,  36, "s2_retry1",      mk(1, 1, 0, 0, 2'd1, 8'd0));
        add_vec(0, 1'b0,  39, "s2_pulse1_end",  mk(1, 1, 0, 0, 2'd1, 8'd0));
        add_vec(0, 1'b0,  40, "s2_wait2",       mk(0, 1, 0, 0, 2'd1, 8'd0));
        add_vec(0, 1'b0,  71, "s2_pre_retry2",  mk(0, 1, 0, 0, 2'd1, 8'd0));
        add_vec(0, 1'b0,  72, "s2_retry2",      mk(1, 1, 0, 0, 2'd2, 8'd0));
        add_vec(0, 1'b0,  76, "s2_wait3",       mk(0, 1, 0, 0, 2'd2, 8'd0));
        add_vec(0, 1'b0, 107, "s2_pre_fault",   mk(0, 1, 0, 0, 2'd2, 8'd0));
        add_vec(0, 1'b0, 108, "s2_fault",       mk(1, 1, 0, 1, 2'd2, 8'd0));
        add_vec(0, 1'b0, 150, "s2_fault_hold",  mk(1, 1, 0, 1, 2'd2, 8'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].restart) reset_dut(vecs[i].lock_lvl);
            run_to(vecs[i].edge_at, vecs[i].lock_lvl);
            check_output(vecs[i].name, vecs[i].exp);
        end

        // Late lock with a one-cycle glitch in STABLE, then a lock loss in RUN.
        reset_dut(1'b0);
        run_to(24, 1'b0);
        run_to(31, 1'b1);
        run_to(32, 1'b0);
        run_to(35, 1'b1);
        check_output("s3_glitch_blocks", mk(0, 1, 0, 0, 2'd0, 8'd0));
        run_to(42, 1'b1);
        check_output("s3_not_ready",     mk(0, 1, 0, 0, 2'd0, 8'd0));
        run_to(43, 1'b1);
        check_output("s3_ready",         mk(0, 0, 1, 0, 2'd0, 8'd0));
        run_to(50, 1'b1);
        run_to(51, 1'b0);
        run_to(52, 1'b1);
        check_output("s4_sync_lag",      mk(0, 0, 1, 0, 2'd0, 8'd0));
        run_to(53, 1'b1);
        check_output("s4_loss",          mk(1, 1, 0, 0, 2'd0, LOSS1));
        run_to(56, 1'b1);
        check_output("s4_pulse_end",     mk(1, 1, 0, 0, 2'd0, LOSS1));
        run_to(57, 1'b1);
        check_output("s4_wait",          mk(0, 1, 0, 0, 2'd0, LOSS1));
        run_to(65, 1'b1);
        check_output("s4_not_ready",     mk(0, 1, 0, 0, 2'd0, LOSS1));
        run_to(66, 1'b1);
        check_output("s4_rerun",         mk(0, 0, 1, 0, 2'd0, LOSS1));

        // Reset in the middle of STABLE, then in FAULT.
        reset_dut(1'b1);
        run_to(8, 1'b1);
        reset_dut(1'b1);
        run_to(12, 1'b1);
        check_output("s5_restart_not_ready", mk(0, 1, 0, 0, 2'd0, 8'd0));
        run_to(13, 1'b1);
        check_output("s5_restart_ready",     mk(0, 0, 1, 0, 2'd0, 8'd0));
        reset_dut(1'b0);
        run_to(110, 1'b0);
        check_output("s5_in_fault",          mk(1, 1, 0, 1, 2'd2, 8'd0));
        reset_dut(1'b0);
        run_to(36, 1'b0);
        check_output("s5_after_fault_retry", mk(1, 1, 0, 0, 2'd1, 8'd0));

`ifdef PLL_RST_SEQ_LOSS_CNT_EN
        // Loss counter saturation.
        reset_dut(1'b1);
        run_to(13, 1'b1);
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b0, 1'b0, 1);
            wait_ready(1'b0, 6, "s6_drop");
            wait_ready(1'b1, 40, "s6_relock");
            if (i == 0) check_output("s6_first_loss", mk(0, 0, 1, 0, 2'd0, 8'd1));
        end
        check_output("s6_saturated", mk(0, 0, 1, 0, 2'd0, 8'hFF));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
